// File: rtl/decoder_n_scan.sv
// Registered one-hot decoder with handshaked direct select and a divided scan sweep.
// Optional saturating wrap counter when DECODER_N_SCAN_WRAPCNT_EN is defined.
module decoder_n_scan #(
   parameter int SEL_W      = 3,
   parameter int ACTIVE_LOW = 0,
   parameter int SCAN_DIV   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  in_valid,
   input  logic [SEL_W-1:0]      in_sel,
   output logic                  in_ready,
   output logic [2**SEL_W-1:0]   out_onehot,
   output logic [SEL_W-1:0]      out_idx,
   output logic                  out_valid,
   output logic                  scan_wrap
`ifdef DECODER_N_SCAN_WRAPCNT_EN
   ,
   output logic [7:0]            wrap_cnt
`endif
);

   localparam int OUT_W = 2**SEL_W;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW != 0}};

   logic [SEL_W-1:0] scan_idx;
   logic [SEL_W-1:0] nxt_idx;
   logic [DIV_W-1:0] div_cnt;
   logic             scan_on;
   logic             scan_run;
   logic             div_hit;
   logic             wrap_hit;

   function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
      logic [OUT_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v ^ IDLE;
   endfunction

   always_comb begin
      in_ready = en & ~mode;
      scan_run = en & mode;
      nxt_idx  = scan_idx + 1'b1;
      div_hit  = (div_cnt == DIV_LAST);
      wrap_hit = scan_run & scan_on & div_hit & (&scan_idx);
   end

   // scan_on marks that the previous edge already ran the scan, so a
   // clear scan_on with scan_run high is the entry edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_onehot <= IDLE;
         out_idx    <= '0;
         out_valid  <= 1'b0;
         scan_wrap  <= 1'b0;
         scan_idx   <= '0;
         div_cnt    <= '0;
         scan_on    <= 1'b0;
      end else if (!en) begin
         out_onehot <= IDLE;
         out_valid  <= 1'b0;
         scan_wrap  <= 1'b0;
         scan_on    <= 1'b0;
      end else if (mode) begin
         scan_on   <= 1'b1;
         out_valid <= 1'b1;
         if (!scan_on) begin
            scan_idx   <= '0;
            div_cnt    <= '0;
            out_idx    <= '0;
            out_onehot <= decode('0);
            scan_wrap  <= 1'b0;
         end else if (div_hit) begin
            div_cnt    <= '0;
            scan_idx   <= nxt_idx;
            out_idx    <= nxt_idx;
            out_onehot <= decode(nxt_idx);
            scan_wrap  <= &scan_idx;
         end else begin
            div_cnt   <= div_cnt + 1'b1;
            scan_wrap <= 1'b0;
         end
      end else begin
         scan_on   <= 1'b0;
         scan_wrap <= 1'b0;
         if (in_valid) begin
            out_idx    <= in_sel;
            out_onehot <= decode(in_sel);
            out_valid  <= 1'b1;
         end
      end
   end

`ifdef DECODER_N_SCAN_WRAPCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         wrap_cnt <= 8'd0;
      else if (wrap_hit && wrap_cnt != 8'hFF)
         wrap_cnt <= wrap_cnt + 8'd1;
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap_hit;
`endif

endmodule
